mvm_output_stream: RTL
======================

MVM_OUTPUT_STREAM -- requirements
Module: mvm_output_stream

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, result word width.
REQ-002 The block SHALL have parameter VEC_LEN, default 3, number of result words per vector y.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 The block SHALL have port wr_en_y, input, 1, result-write strobe from the control stage.
REQ-006 The block SHALL have port addr_y, input, 2, index of the result word being written (0..VEC_LEN-1).
REQ-007 The block SHALL have port y_in, input, DATA_WIDTH, result word from the accumulator.
REQ-008 The block SHALL have port out_data, output, DATA_WIDTH, streamed result word.
REQ-009 The block SHALL have port out_valid, output, 1, out_data is valid.
REQ-010 The block SHALL have port out_last, output, 1, current word is index VEC_LEN-1 of its vector.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts the word.
REQ-012 The block SHALL have port busy, output, 1, both banks hold unsent vectors; control must not start a new multiply.
REQ-013 The block SHALL have port overflow, output, 1, sticky flag: a write was dropped.
REQ-014 The block SHALL have port vec_count, output, 8, count of vectors fully streamed.

Function
REQ-015 The block SHALL hold two banks (ping-pong) of VEC_LEN words, each with a full flag; fill_sel selects the write bank and rd_sel the read bank.
REQ-016 A write (wr_en_y=1 at a rising edge) SHALL store y_in at addr_y of bank fill_sel when that bank is not full.
REQ-017 A write with addr_y = VEC_LEN-1 SHALL set that bank's full flag and toggle fill_sel at the same edge (commit).
REQ-018 A write with addr_y >= VEC_LEN SHALL be ignored, with no state change.
REQ-019 A write to a full fill bank SHALL be dropped and SHALL set overflow; overflow clears only on reset.
REQ-020 The stream FSM SHALL have states IDLE and SEND, with word index idx from 0 to VEC_LEN-1.
REQ-021 IDLE -> SEND SHALL occur at the first edge on which bank rd_sel is full; idx = 0.
REQ-022 Commit latency: a commit at edge k SHALL give out_valid=1 after edge k+1 if the FSM was IDLE.
REQ-023 In SEND, out_valid SHALL be 1 and out_data SHALL be word idx of bank rd_sel, held stable until out_ready=1.
REQ-024 out_last SHALL be 1 exactly when out_valid=1 and idx = VEC_LEN-1.
REQ-025 On handshake (out_valid & out_ready) with idx < VEC_LEN-1, idx SHALL increment.
REQ-026 On handshake with idx = VEC_LEN-1: clear rd bank full, toggle rd_sel, increment vec_count (255 wraps to 0), reset idx to 0.
REQ-027 After a last-word handshake, the FSM SHALL stay in SEND if the other bank is full (no bubble); otherwise it SHALL go to IDLE.
REQ-028 A commit and a last-word release on the same edge SHALL both take effect; the newly freed bank is writable on the next edge.
REQ-029 busy SHALL equal (bank0 full AND bank1 full), registered state only.
REQ-030 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-031 On reset: banks and full flags 0, fill_sel=0, rd_sel=0, FSM IDLE, idx=0, out_valid=0, out_last=0, out_data=0, busy=0, overflow=0, vec_count=0.
REQ-032 Reset mid-stream SHALL abort immediately; partial and committed vectors are discarded.

Structure
REQ-033 Package mvm_pkg SHALL hold DATA_WIDTH, VEC_LEN, and the FSM state enum (IDLE, SEND) shared with the control stage.
REQ-034 The single sub-module mvm_y_bank SHALL implement one VEC_LEN-word bank with its full flag; it SHALL be instantiated twice.

Verification
REQ-035 Bench SHALL cover: write 10,20,30 to addr 0,1,2, out_ready=1 -> out_data 10,20,30 on three consecutive cycles starting 2 cycles after first commit edge; out_last on 30; vec_count=1.
REQ-036 Bench SHALL cover: same vector with out_ready toggling 0/1 each cycle -> each word held stable while stalled; sequence 10,20,30 unchanged.
REQ-037 Bench SHALL cover: two vectors (1,2,3 then 4,5,6) committed with out_ready=0 -> busy=1; third-vector write -> overflow=1; release out_ready -> 1..6 streamed back-to-back, no bubble; busy falls after the word 3 handshake.
REQ-038 Bench SHALL cover: commit of second vector on the same edge as the last-word handshake of the first -> no loss; vec_count reaches 2.
REQ-039 Bench SHALL cover: reset asserted asynchronously mid-SEND after word 20 -> out_valid=0 at once; all outputs at reset values; the next vector streams normally.
REQ-040 Bench SHALL cover: write with addr_y=3 -> ignored; 256 vectors streamed -> vec_count wraps to 0.

Source files
------------

// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared sizes and stream FSM states for the MVM output stage
package mvm_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int VEC_LEN    = 3;
  localparam int ADDR_WIDTH = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } stream_state_e;

endpackage

// File: rtl/mvm_y_bank.sv
// rtl/mvm_y_bank.sv - one VEC_LEN-word result bank with its full flag
module mvm_y_bank #(
  parameter int DATA_WIDTH = mvm_pkg::DATA_WIDTH,
  parameter int VEC_LEN    = mvm_pkg::VEC_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  set_full,
  input  logic                  clr_full,
  input  logic [1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem_q [VEC_LEN];
  logic [DATA_WIDTH-1:0] mem_d [VEC_LEN];
  logic                  full_q;
  logic                  full_d;

  // The top only writes/reads in-range addresses, so no bounds handling here.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
    full_d = full_q;
    if (clr_full) begin
      full_d = 1'b0;
    end
    if (set_full) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        mem_q[i] <= '0;
      end
      full_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      full_q <= full_d;
    end
  end

  assign rd_data = mem_q[rd_addr];
  assign full    = full_q;

endmodule

// File: rtl/mvm_output_stream.sv
// rtl/mvm_output_stream.sv - ping-pong result buffer streaming vectors y downstream
module mvm_output_stream #(
  parameter int DATA_WIDTH = mvm_pkg::DATA_WIDTH,
  parameter int VEC_LEN    = mvm_pkg::VEC_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_y,
  input  logic [1:0]            addr_y,
  input  logic [DATA_WIDTH-1:0] y_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overflow,
  output logic [7:0]            vec_count
);

  import mvm_pkg::*;

  localparam logic [1:0] LAST_IDX = 2'(VEC_LEN - 1);

  stream_state_e state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic          fill_sel_q, fill_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    vec_count_q, vec_count_d;

  logic                  full0, full1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  wr_valid, fill_full, rd_full, other_full;
  logic                  accept, commit, handshake, last_hs;

  always_comb begin
    wr_valid   = wr_en_y && (addr_y <= LAST_IDX);
    fill_full  = fill_sel_q ? full1 : full0;
    rd_full    = rd_sel_q ? full1 : full0;
    other_full = rd_sel_q ? full0 : full1;
    accept     = wr_valid && !fill_full;
    commit     = accept && (addr_y == LAST_IDX);
    handshake  = (state_q == SEND) && out_ready;
    last_hs    = handshake && (idx_q == LAST_IDX);

    fill_sel_d  = fill_sel_q ^ commit;
    rd_sel_d    = rd_sel_q ^ last_hs;
    overflow_d  = overflow_q | (wr_valid && fill_full);
    vec_count_d = last_hs ? vec_count_q + 8'd1 : vec_count_q;

    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (rd_full) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        // Stay in SEND across vectors when the other bank is already waiting.
        if (last_hs) begin
          idx_d   = '0;
          state_d = other_full ? SEND : IDLE;
        end else if (handshake) begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      fill_sel_q  <= 1'b0;
      rd_sel_q    <= 1'b0;
      overflow_q  <= 1'b0;
      vec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fill_sel_q  <= fill_sel_d;
      rd_sel_q    <= rd_sel_d;
      overflow_q  <= overflow_d;
      vec_count_q <= vec_count_d;
    end
  end

  mvm_y_bank #(.DATA_WIDTH(DATA_WIDTH), .VEC_LEN(VEC_LEN)) u_bank0 (
    .clk      (clk),
    .rst      (reset),
    .wr_en    (accept && !fill_sel_q),
    .wr_addr  (addr_y),
    .wr_data  (y_in),
    .set_full (commit && !fill_sel_q),
    .clr_full (last_hs && !rd_sel_q),
    .rd_addr  (idx_q),
    .rd_data  (rdata0),
    .full     (full0)
  );

  mvm_y_bank #(.DATA_WIDTH(DATA_WIDTH), .VEC_LEN(VEC_LEN)) u_bank1 (
    .clk      (clk),
    .rst      (reset),
    .wr_en    (accept && fill_sel_q),
    .wr_addr  (addr_y),
    .wr_data  (y_in),
    .set_full (commit && fill_sel_q),
    .clr_full (last_hs && rd_sel_q),
    .rd_addr  (idx_q),
    .rd_data  (rdata1),
    .full     (full1)
  );

  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_data  = out_valid ? (rd_sel_q ? rdata1 : rdata0) : '0;
  assign busy      = full0 && full1;
  assign overflow  = overflow_q;
  assign vec_count = vec_count_q;

endmodule
